lfsr_recover: RTL and testbench

- Receive-side counterpart of the team's 2-bit-per-step scrambling LFSR noise source.
- Source model: 32-bit register; each enabled step shifts left by 2 and loads bit1 = !(reg[31] ^ d[1]), bit0 = d[0]. It publishes the 16-bit signed word reg[31:16].
- This block watches that 16-bit word stream, checks step-to-step consistency, acquires lock, and recovers the 2-bit payload d[1:0] that was injected 8 steps earlier.
- Sits downstream of the noise source, for loopback checking and sideband data extraction.

---
 rtl/lfsr_recover.sv | 155 +++++++++++++++
 tb/tb_lfsr_recover.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_recover.sv
// Receive-side tracker for the 2-bit-per-step scrambling LFSR noise source: checks word
// continuity, acquires lock, recovers injected payload. Optional sym_count: LFSR_RECOVER_CNT_EN.
module lfsr_recover #(
  parameter int ERR_W    = 8,
  parameter int MISS_TOL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      in16,
  input  logic             in_valid,
  output logic [1:0]       data_out,
  output logic             data_valid,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
`ifdef LFSR_RECOVER_CNT_EN
  ,
  output logic [15:0]      sym_count
`endif
);

  typedef enum logic {ST_FILL, ST_LOCKED} state_t;

  localparam logic [3:0] MISS_LIM = 4'(MISS_TOL);
  localparam logic [3:0] FILL_LIM = 4'd9;

  state_t           state_reg, state_next;
  logic [15:0]      prev_reg, prev_next;
  logic             first_reg, first_next;
  logic [8:0]       hist_reg, hist_next;
  logic [3:0]       fill_reg, fill_next;
  logic [3:0]       miss_reg, miss_next;
  logic [ERR_W-1:0] err_reg, err_next;
  logic [1:0]       dout_reg, dout_next;
  logic             dvalid_reg, dvalid_next;
  logic             drop;

  logic [8:0]       hist_shift;
  logic             consistent;
  logic [1:0]       recovered;
  logic [3:0]       fill_inc;
  logic [3:0]       miss_inc;

  // hist_reg[8] is the sign bit of the sample nine accepted samples back
  assign hist_shift[0] = in16[15];
  for (genvar gi = 1; gi < 9; gi++) begin : g_hist
    assign hist_shift[gi] = hist_reg[gi-1];
  end

  assign consistent = first_reg || (in16[15:2] == prev_reg[13:0]);
  assign recovered  = {~(in16[1] ^ hist_reg[8]), in16[0]};
  assign fill_inc   = fill_reg + 4'd1;
  assign miss_inc   = miss_reg + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_FILL;
      prev_reg   <= '0;
      first_reg  <= 1'b1;
      hist_reg   <= '0;
      fill_reg   <= '0;
      miss_reg   <= '0;
      err_reg    <= '0;
      dout_reg   <= '0;
      dvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      prev_reg   <= prev_next;
      first_reg  <= first_next;
      hist_reg   <= hist_next;
      fill_reg   <= fill_next;
      miss_reg   <= miss_next;
      err_reg    <= err_next;
      dout_reg   <= dout_next;
      dvalid_reg <= dvalid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    prev_next   = prev_reg;
    first_next  = first_reg;
    hist_next   = hist_reg;
    fill_next   = fill_reg;
    miss_next   = miss_reg;
    err_next    = err_reg;
    dout_next   = dout_reg;
    dvalid_next = 1'b0;
    drop        = 1'b0;

    if (in_valid) begin
      // every sample, good or bad, becomes the reference for the next one
      prev_next  = in16;
      first_next = 1'b0;
      hist_next  = hist_shift;

      unique case (state_reg)
        ST_FILL: begin
          if (consistent) begin
            fill_next = fill_inc;
            if (fill_inc == FILL_LIM) begin
              state_next = ST_LOCKED;
              miss_next  = '0;
            end
          end else begin
            fill_next = 4'd1;
          end
        end

        ST_LOCKED: begin
          if (consistent) begin
            dout_next   = recovered;
            dvalid_next = 1'b1;
            miss_next   = '0;
          end else if (miss_inc >= MISS_LIM) begin
            // the slipping sample counts as the first of the new fill run
            drop       = 1'b1;
            state_next = ST_FILL;
            fill_next  = 4'd1;
            first_next = 1'b1;
            miss_next  = '0;
            if (err_reg != {ERR_W{1'b1}}) begin
              err_next = err_reg + 1'b1;
            end
          end else begin
            miss_next = miss_inc;
          end
        end

        default: state_next = ST_FILL;
      endcase
    end
  end

  assign data_out   = dout_reg;
  assign data_valid = dvalid_reg;
  assign locked     = (state_reg == ST_LOCKED);
  assign err_count  = err_reg;

`ifdef LFSR_RECOVER_CNT_EN
  logic [15:0] sym_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_reg <= '0;
    end else if (drop) begin
      sym_reg <= '0;
    end else if (dvalid_next) begin
      sym_reg <= sym_reg + 16'd1;
    end
  end

  assign sym_count = sym_reg;
`endif

endmodule

// File: tb/tb_lfsr_recover.sv
// Directed bench for lfsr_recover: golden source model, acquisition, payload tracking,
// gaps, slips with error saturation (second instance, ERR_W=2) and async reset.
module tb_lfsr_recover;

  logic        clk;
  logic        reset;
  logic [15:0] in16;
  logic        in_valid;
  logic [1:0]  data_out,  data_out2;
  logic        data_valid, data_valid2;
  logic        locked,    locked2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;
`ifdef LFSR_RECOVER_CNT_EN
  logic [15:0] sym_count, sym_count2;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] src;
  logic [1:0]  pay_log [0:255];
  int          step_n;

  lfsr_recover #(.ERR_W(8), .MISS_TOL(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in16       (in16),
    .in_valid   (in_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .err_count  (err_count)
`ifdef LFSR_RECOVER_CNT_EN
    ,
    .sym_count  (sym_count)
`endif
  );

  lfsr_recover #(.ERR_W(2), .MISS_TOL(1)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .in16       (in16),
    .in_valid   (in_valid),
    .data_out   (data_out2),
    .data_valid (data_valid2),
    .locked     (locked2),
    .err_count  (err_count2)
`ifdef LFSR_RECOVER_CNT_EN
    ,
    .sym_count  (sym_count2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // source step: shift by 2, bit1 = !(msb ^ d1), bit0 = d0
  task automatic src_step(input logic [1:0] d);
    src = {src[29:0], ~(src[31] ^ d[1]), d[0]};
    step_n++;
    pay_log[step_n] = d;
  endtask

  task automatic tick(input logic [15:0] w, input logic v);
    in16     = w;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic exp_lk, input logic exp_dv, input logic chk_val);
    src_step(d);
    tick(src[31:16], 1'b1);
    check($sformatf("locked@%0d", step_n), 32'(locked), 32'(exp_lk));
    check($sformatf("data_valid@%0d", step_n), 32'(data_valid), 32'(exp_dv));
    if (chk_val) begin
      check($sformatf("data_out@%0d", step_n), 32'(data_out), 32'(pay_log[step_n-8]));
    end
    $display("[TB] step %0d in16=%04h locked=%0b dv=%0b dout=%0b err=%0d",
             step_n, src[31:16], locked, data_valid, data_out, err_count);
  endtask

  task automatic slip(input int n);
    tick(16'hFFFF, 1'b1);
    check($sformatf("slip%0d_dv", n), 32'(data_valid), 32'd0);
    check($sformatf("slip%0d_locked", n), 32'(locked), 32'd0);
    check($sformatf("slip%0d_err", n), 32'(err_count), 32'(n));
    check($sformatf("slip%0d_err_sat", n), 32'(err_count2), 32'((n > 3) ? 3 : n));
    $display("[TB] slip %0d locked=%0b err=%0d err2=%0d", n, locked, err_count, err_count2);
  endtask

  initial begin
    src      = '0;
    step_n   = 0;
    reset    = 1'b1;
    in16     = '0;
    in_valid = 1'b0;
    #12;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // acquisition with constant payload 10
    for (int k = 1; k <= 30; k++) begin
      send(2'b10, k >= 9, k >= 10, k >= 10);
`ifdef LFSR_RECOVER_CNT_EN
      if (k == 29) check("sym_20", 32'(sym_count), 32'd20);
`endif
    end
    check("acq_err", 32'(err_count), 32'd0);

    // first slip and relock
    slip(1);
    check("slip_dout_hold", 32'(data_out), 32'(2'b10));
`ifdef LFSR_RECOVER_CNT_EN
    check("sym_clear", 32'(sym_count), 32'd0);
`endif
    for (int j = 1; j <= 28; j++) begin
      send(2'b10, j >= 8, j >= 9, j >= 10);
    end
`ifdef LFSR_RECOVER_CNT_EN
    check("sym_relock", 32'(sym_count), 32'd20);
`endif

    // payload tracking 00,01,10,11
    for (int i = 0; i < 16; i++) begin
      send(2'(i % 4), 1'b1, 1'b1, 1'b1);
    end

    // gap pattern 1,0,0,1
    send(2'b10, 1'b1, 1'b1, 1'b1);
    for (int g = 0; g < 2; g++) begin
      tick(16'hA5A5, 1'b0);
      check($sformatf("gap%0d_dv", g), 32'(data_valid), 32'd0);
      check($sformatf("gap%0d_dout", g), 32'(data_out), 32'(pay_log[step_n-8]));
      check($sformatf("gap%0d_locked", g), 32'(locked), 32'd1);
      $display("[TB] gap %0d dv=%0b dout=%0b", g, data_valid, data_out);
    end
    send(2'b10, 1'b1, 1'b1, 1'b1);

    // flush payload 10 so the forced word cannot match, then repeated slips
    for (int i = 0; i < 9; i++) begin
      send(2'b10, 1'b1, 1'b1, 1'b1);
    end
    for (int n = 2; n <= 5; n++) begin
      slip(n);
      for (int j = 1; j <= 12; j++) begin
        send(2'b10, j >= 8, j >= 9, j >= 10);
      end
    end

    // async reset between edges while locked with a pulse active
    #3;
    reset = 1'b1;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_dv", 32'(data_valid), 32'd0);
    check("arst_dout", 32'(data_out), 32'd0);
    check("arst_err", 32'(err_count), 32'd0);
    check("arst_err2", 32'(err_count2), 32'd0);
`ifdef LFSR_RECOVER_CNT_EN
    check("arst_sym", 32'(sym_count), 32'd0);
`endif
    $display("[TB] async reset locked=%0b dv=%0b dout=%0b err=%0d", locked, data_valid, data_out, err_count);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
